periph_bus_initiator: RTL

PERIPH_BUS_INITIATOR -- requirements
Module: periph_bus_initiator

---
 rtl/periph_bus_initiator.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/periph_bus_initiator.sv
// Purpose : single-outstanding bus initiator turning a cmd valid/ready request into a req/gnt bus access plus an ID-matched response.
// Latency : 3 cycles from the cmd handshake to rsp_valid_o, reached when gnt_i arrives in the first REQ cycle and r_valid_i one cycle later.
// Backpres: cmd_ready_o is high only when idle; rsp_valid_o and its data are held until rsp_ready_i, and req_o is held until gnt_i.
//
// Ports:
//   clk_i, rst_ni                   clock, synchronous active-low reset
//   cmd_valid_i/cmd_ready_o         command handshake; cmd_addr_i, cmd_wen_i (1=read), cmd_wdata_i, cmd_be_i
//   req_o/gnt_i                     bus request/grant; add_o, wen_o, wdata_o, be_o, id_o
//   r_valid_i                       bus response; r_rdata_i, r_opc_i (1=error), r_id_i
//   rsp_valid_o/rsp_ready_i         response handshake; rsp_rdata_o, rsp_err_o
//   busy_o                          a transaction is in progress
// Build option: define PERIPH_INIT_TIMEOUT_EN to add a response timeout of
// TIMEOUT_CYCLES cycles. An expired timeout returns rsp_err_o=1 with zero data.
module periph_bus_initiator #(
    parameter int unsigned          ID_WIDTH       = 5,
    parameter logic [ID_WIDTH-1:0]  ID_VALUE       = '0,
    parameter int unsigned          TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic [31:0]         cmd_addr_i,
    input  logic                cmd_wen_i,
    input  logic [31:0]         cmd_wdata_i,
    input  logic [3:0]          cmd_be_i,
    output logic                req_o,
    output logic [31:0]         add_o,
    output logic                wen_o,
    output logic [31:0]         wdata_o,
    output logic [3:0]          be_o,
    output logic [ID_WIDTH-1:0] id_o,
    input  logic                gnt_i,
    input  logic                r_valid_i,
    input  logic [31:0]         r_rdata_i,
    input  logic                r_opc_i,
    input  logic [ID_WIDTH-1:0] r_id_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [31:0]         rsp_rdata_o,
    output logic                rsp_err_o,
    output logic                busy_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
        $error("TIMEOUT_CYCLES must lie in 1..65535");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_RSP_OUT  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] add_q, add_d;
    logic        wen_q, wen_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_match;

`ifdef PERIPH_INIT_TIMEOUT_EN
    // The counter value TO_LAST marks the final permitted WAIT_RSP cycle.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;
`endif

    // Only responses that carry our own ID count; others belong to someone else.
    assign rsp_match = r_valid_i && (r_id_i == ID_VALUE);

    always_comb begin
        state_d     = state_q;
        add_d       = add_q;
        wen_d       = wen_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef PERIPH_INIT_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    add_d   = cmd_addr_i;
                    wen_d   = cmd_wen_i;
                    wdata_d = cmd_wdata_i;
                    be_d    = cmd_be_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // r_valid_i is deliberately not looked at here, even in the grant cycle.
                if (gnt_i) begin
                    state_d = ST_WAIT_RSP;
`ifdef PERIPH_INIT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_WAIT_RSP: begin
                if (rsp_match) begin
                    // A matching response wins over a timeout that expires in the same cycle.
                    rsp_rdata_d = r_rdata_i;
                    rsp_err_d   = r_opc_i;
                    state_d     = ST_RSP_OUT;
                end
`ifdef PERIPH_INIT_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RSP_OUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ST_RSP_OUT: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            add_q       <= '0;
            wen_q       <= 1'b1;
            wdata_q     <= '0;
            be_q        <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef PERIPH_INIT_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            add_q       <= add_d;
            wen_q       <= wen_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef PERIPH_INIT_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Bus fields come straight from the command registers, so they hold their
    // last value while idle and stay constant for the whole REQ phase.
    assign cmd_ready_o = (state_q == ST_IDLE);
    assign req_o       = (state_q == ST_REQ);
    assign rsp_valid_o = (state_q == ST_RSP_OUT);
    assign busy_o      = (state_q != ST_IDLE);
    assign add_o       = add_q;
    assign wen_o       = wen_q;
    assign wdata_o     = wdata_q;
    assign be_o        = be_q;
    assign id_o        = ID_VALUE;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
